csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_unit.sv | 190 +++++++++++++++++++
 tb/tb_csr_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mscratch/mepc/mcause/mip, 64-bit cycle and
// instret counters, mhartid, plus trap entry/return sequencing and interrupt pending.
module csr_unit #(
  parameter int unsigned       XLEN      = 32,
  parameter logic [XLEN-1:0]   HART_ID   = '0,
  parameter logic [XLEN-1:0]   MTVEC_RST = XLEN'(32'h0000_0100)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       csr_addr,
  input  logic [1:0]        csr_op,
  input  logic [XLEN-1:0]   csr_wdata,
  output logic [XLEN-1:0]   csr_rdata,
  output logic              csr_illegal,
  input  logic              instr_retire,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_cause,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic              mret,
  input  logic              irq_ext,
  output logic [XLEN-1:0]   trap_vector,
  output logic [XLEN-1:0]   epc,
  output logic              irq_pending
);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam bit IS_RV32 = (XLEN == 32);

  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic            meie_q, meie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;

  csr_op_e         op;
  logic            impl;
  logic            read_only;
  logic            wr_intent;
  logic            csr_we;
  logic [XLEN-1:0] rval;
  logic [XLEN-1:0] wval;
  logic [XLEN-1:0] tv_base;

  assign op = csr_op_e'(csr_op);

  always_comb begin
    impl = 1'b1;
    rval = '0;
    case (csr_addr)
      ADDR_MSTATUS: begin
        rval[3] = mie_q;
        rval[7] = mpie_q;
      end
      ADDR_MIE:       rval[11] = meie_q;
      ADDR_MTVEC: begin
        rval    = mtvec_q;
        rval[1] = 1'b0;
      end
      ADDR_MSCRATCH:  rval = mscratch_q;
      ADDR_MEPC:      rval = mepc_q;
      ADDR_MCAUSE:    rval = mcause_q;
      ADDR_MIP:       rval[11] = irq_ext;
      ADDR_MCYCLE:    rval = XLEN'(mcycle_q);
      ADDR_MINSTRET:  rval = XLEN'(minstret_q);
      ADDR_MCYCLEH: begin
        impl = IS_RV32;
        rval = IS_RV32 ? XLEN'(mcycle_q >> 32) : '0;
      end
      ADDR_MINSTRETH: begin
        impl = IS_RV32;
        rval = IS_RV32 ? XLEN'(minstret_q >> 32) : '0;
      end
      ADDR_MHARTID:   rval = HART_ID;
      default:        impl = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so it is legal even on read-only CSRs.
  assign read_only   = (csr_addr[11:10] == 2'b11) || (csr_addr == ADDR_MIP);
  assign wr_intent   = (op == OP_RW) ||
                       (((op == OP_RS) || (op == OP_RC)) && (csr_wdata != '0));
  assign csr_illegal = (op != OP_NONE) && (!impl || (wr_intent && read_only));
  assign csr_rdata   = ((op != OP_NONE) && impl) ? rval : '0;
  assign csr_we      = wr_intent && !csr_illegal;

  always_comb begin
    case (op)
      OP_RW:   wval = csr_wdata;
      OP_RS:   wval = rval | csr_wdata;
      OP_RC:   wval = rval & ~csr_wdata;
      default: wval = rval;
    endcase
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    meie_d     = meie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + 64'(instr_retire);

    if (trap_valid) begin
      mepc_d   = {trap_pc[XLEN-1:2], 2'b00};
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we) begin
      // A counter-half write overrides the incremented value, which is what suppresses the tick.
      case (csr_addr)
        ADDR_MSTATUS: begin
          mie_d  = wval[3];
          mpie_d = wval[7];
        end
        ADDR_MIE:       meie_d     = wval[11];
        ADDR_MTVEC:     mtvec_d    = {wval[XLEN-1:2], 1'b0, wval[0]};
        ADDR_MSCRATCH:  mscratch_d = wval;
        ADDR_MEPC:      mepc_d     = {wval[XLEN-1:2], 2'b00};
        ADDR_MCAUSE:    mcause_d   = wval;
        ADDR_MCYCLE:
          mcycle_d = IS_RV32 ? {mcycle_q[63:32], wval[31:0]} : 64'(wval);
        ADDR_MINSTRET:
          minstret_d = IS_RV32 ? {minstret_q[63:32], wval[31:0]} : 64'(wval);
        ADDR_MCYCLEH:   mcycle_d   = {wval[31:0], mcycle_q[31:0]};
        ADDR_MINSTRETH: minstret_d = {wval[31:0], minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      meie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      meie_q     <= meie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign tv_base     = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_vector = (mtvec_q[0] && trap_cause[XLEN-1]) ?
                       tv_base + {trap_cause[XLEN-3:0], 2'b00} : tv_base;
  assign epc         = mepc_q;
  assign irq_pending = mie_q & meie_q & irq_ext;

endmodule

// File: tb/tb_csr_unit.sv
// Directed-vector bench for csr_unit (XLEN=32, HART_ID=5) with hand-computed expectations.
module tb_csr_unit;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            instr_retire;
  logic            trap_valid;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic            mret;
  logic            irq_ext;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] epc;
  logic            irq_pending;

  int unsigned n_chk;
  int unsigned n_pass;

  csr_unit #(
    .XLEN    (XLEN),
    .HART_ID (32'd5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .csr_addr     (csr_addr),
    .csr_op       (csr_op),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .csr_illegal  (csr_illegal),
    .instr_retire (instr_retire),
    .trap_valid   (trap_valid),
    .trap_cause   (trap_cause),
    .trap_pc      (trap_pc),
    .mret         (mret),
    .irq_ext      (irq_ext),
    .trap_vector  (trap_vector),
    .epc          (epc),
    .irq_pending  (irq_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    else
      n_pass++;
  endtask

  // Legal read-only access: RS with zero operand; advances 1 ns, no clock edge.
  task automatic rd(input logic [11:0] addr, output logic [XLEN-1:0] data,
                    output logic ill);
    csr_addr  = addr;
    csr_op    = 2'b10;
    csr_wdata = '0;
    #1;
    data      = csr_rdata;
    ill       = csr_illegal;
    csr_op    = 2'b00;
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [XLEN-1:0] data);
    csr_addr  = addr;
    csr_op    = op;
    csr_wdata = data;
    @(posedge clk);
    #1;
    csr_op    = 2'b00;
    csr_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [XLEN-1:0] d;
  logic            il;

  initial begin
    n_chk        = 0;
    n_pass       = 0;
    rst          = 1'b0;
    csr_addr     = '0;
    csr_op       = 2'b00;
    csr_wdata    = '0;
    instr_retire = 1'b0;
    trap_valid   = 1'b0;
    trap_cause   = '0;
    trap_pc      = '0;
    mret         = 1'b0;
    irq_ext      = 1'b0;

    #2;
    chk("rst_epc", 64'(epc), 64'h0);
    chk("rst_irq_pending", 64'(irq_pending), 64'h0);
    csr_addr = 12'h7C0;
    csr_op   = 2'b01;
    #1;
    chk("rst_illegal_follows_inputs", 64'(csr_illegal), 64'h1);
    csr_op   = 2'b00;

    @(negedge clk);
    rst = 1'b1;
    #1;
    rd(12'h300, d, il); chk("rst_mstatus", 64'(d), 64'h0);
    rd(12'h305, d, il); chk("rst_mtvec", 64'(d), 64'h100);
    rd(12'hB00, d, il); chk("rst_mcycle", 64'(d), 64'h0);
    step();
    rd(12'hB00, d, il); chk("mcycle_first_tick", 64'(d), 64'h1);

    // op none: no read, no flag
    csr_addr = 12'h305;
    csr_op   = 2'b00;
    #1;
    chk("op_none_rdata", 64'(csr_rdata), 64'h0);
    chk("op_none_illegal", 64'(csr_illegal), 64'h0);

    wr(2'b10, 12'h300, 32'h8);
    rd(12'h300, d, il); chk("mstatus_rs", 64'(d), 64'h8);
    wr(2'b11, 12'h300, 32'h8);
    rd(12'h300, d, il); chk("mstatus_rc", 64'(d), 64'h0);
    wr(2'b01, 12'h300, 32'hFFFF_FFFF);
    rd(12'h300, d, il); chk("mstatus_rw_mask", 64'(d), 64'h88);

    // trap setup: MIE=1, MEIE=1, vectored mtvec
    wr(2'b01, 12'h300, 32'h8);
    wr(2'b01, 12'h305, 32'h103);
    rd(12'h305, d, il); chk("mtvec_bit1_zero", 64'(d), 64'h101);
    wr(2'b01, 12'h304, 32'hFFFF_FFFF);
    rd(12'h304, d, il); chk("mie_mask", 64'(d), 64'h800);
    irq_ext = 1'b1;
    #1;
    chk("irq_pending_set", 64'(irq_pending), 64'h1);

    trap_valid = 1'b1;
    trap_cause = 32'h8000_000B;
    trap_pc    = 32'h0000_1236;
    csr_addr   = 12'h340;
    csr_op     = 2'b01;
    csr_wdata  = 32'h55;
    #1;
    chk("trap_vector_vectored", 64'(trap_vector), 64'h12C);
    step();
    trap_valid = 1'b0;
    csr_op     = 2'b00;
    chk("trap_epc", 64'(epc), 64'h1234);
    rd(12'h300, d, il); chk("trap_mstatus", 64'(d), 64'h80);
    rd(12'h342, d, il); chk("trap_mcause", 64'(d), 64'h8000_000B);
    rd(12'h340, d, il); chk("trap_drops_csr_write", 64'(d), 64'h0);
    chk("irq_pending_masked", 64'(irq_pending), 64'h0);
    trap_cause = 32'h0000_000B;
    #1;
    chk("trap_vector_direct", 64'(trap_vector), 64'h100);

    mret = 1'b1;
    step();
    mret = 1'b0;
    rd(12'h300, d, il); chk("mret_mstatus", 64'(d), 64'h88);

    trap_valid = 1'b1;
    mret       = 1'b1;
    trap_cause = 32'h7;
    trap_pc    = 32'h2000;
    step();
    trap_valid = 1'b0;
    mret       = 1'b0;
    rd(12'h300, d, il); chk("trap_over_mret_mstatus", 64'(d), 64'h80);
    chk("trap_over_mret_epc", 64'(epc), 64'h2000);
    rd(12'h342, d, il); chk("trap_over_mret_mcause", 64'(d), 64'h7);

    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    wr(2'b01, 12'hB80, 32'h0);
    step();
    rd(12'hB80, d, il); chk("mcycleh_carry", 64'(d), 64'h1);
    rd(12'hB00, d, il); chk("mcycle_wrap", 64'(d), 64'h0);

    rd(12'hB02, d, il); chk("minstret_idle", 64'(d), 64'h0);
    instr_retire = 1'b1;
    step(); step(); step();
    rd(12'hB02, d, il); chk("minstret_count", 64'(d), 64'h3);
    wr(2'b01, 12'hB02, 32'h10);
    instr_retire = 1'b0;
    rd(12'hB02, d, il); chk("minstret_write_suppress", 64'(d), 64'h10);

    csr_addr  = 12'hF14;
    csr_op    = 2'b01;
    csr_wdata = 32'h1234;
    #1;
    chk("mhartid_rw_illegal", 64'(csr_illegal), 64'h1);
    step();
    csr_op = 2'b00;
    rd(12'hF14, d, il);
    chk("mhartid_read_legal", 64'(il), 64'h0);
    chk("mhartid_value", 64'(d), 64'h5);
    rd(12'h7C0, d, il);
    chk("unimpl_illegal", 64'(il), 64'h1);
    chk("unimpl_rdata", 64'(d), 64'h0);
    rd(12'h344, d, il); chk("mip_meip", 64'(d), 64'h800);
    csr_addr  = 12'h344;
    csr_op    = 2'b11;
    csr_wdata = 32'h800;
    #1;
    chk("mip_rc_illegal", 64'(csr_illegal), 64'h1);
    csr_op    = 2'b00;
    csr_wdata = '0;

    wr(2'b01, 12'h340, 32'hAB);
    rd(12'h340, d, il); chk("mscratch_write", 64'(d), 64'hAB);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_epc", 64'(epc), 64'h0);
    rd(12'h340, d, il); chk("async_rst_mscratch", 64'(d), 64'h0);
    rd(12'h300, d, il); chk("async_rst_mstatus", 64'(d), 64'h0);
    rd(12'h305, d, il); chk("async_rst_mtvec", 64'(d), 64'h100);

    trap_valid = 1'b1;
    trap_pc    = 32'h3000;
    step();
    chk("rst_blocks_trap", 64'(epc), 64'h0);
    trap_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
